dffn_pipe_rs: RTL and testbench



---
 rtl/gf180mcu_pipe_pkg.sv | 32 +++
 rtl/dffn_pipe_stage.sv | 39 +++
 rtl/dffn_pipe_rs.sv | 106 ++++++++++
 tb/tb_dffn_pipe_rs.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_pipe_pkg.sv
// Shared definitions for the negative-edge pipeline cells: the per-edge mode
// encoding, a constant log2 helper and an elaboration-time parameter range check.
`ifndef GF180MCU_PIPE_PKG_SV
`define GF180MCU_PIPE_PKG_SV

`define PIPE_RANGE_CHECK(VAL, LO, HI) \
    if (((VAL) < (LO)) || ((VAL) > (HI))) begin \
        $error("dffn_pipe parameter out of range"); \
    end

package gf180mcu_pipe_pkg;

    // The encoding order mirrors priority: a higher code wins at the edge.
    typedef enum logic [1:0] {
        MODE_HOLD  = 2'd0,
        MODE_SHIFT = 2'd1,
        MODE_SCAN  = 2'd2,
        MODE_SET   = 2'd3
    } mode_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

`endif

// File: rtl/dffn_pipe_stage.sv
// One WIDTH-bit falling-edge stage: async reset, sync set, parallel load from
// the previous stage, or a one-bit shift when stitched into the scan chain.
module dffn_pipe_stage
    import gf180mcu_pipe_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
    input  logic             i_clkn,
    input  logic             i_rst,
    input  mode_e            i_mode,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_si,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_scan;

    // Dropping the top bit of {r_q, i_si} is a left shift that also works for WIDTH=1.
    assign w_scan = WIDTH'({r_q, i_si});

    always_ff @(negedge i_clkn or posedge i_rst) begin
        if (i_rst) begin
            r_q <= RESET_VAL;
        end else begin
            case (i_mode)
                MODE_SET:   r_q <= SET_VAL;
                MODE_SCAN:  r_q <= w_scan;
                MODE_SHIFT: r_q <= i_d;
                default:    r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/dffn_pipe_rs.sv
// DEPTH-stage falling-edge register pipeline with enable, sync set, serial scan
// and a saturating fill counter that flags when DEPTH valid entries are held.
module dffn_pipe_rs
    import gf180mcu_pipe_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
    input  logic             CLKN,
    input  logic             R,
    input  logic             E,
    input  logic             SET,
    input  logic             SE,
    input  logic             SI,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    output logic             SO
);

    localparam int           CW   = clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    `PIPE_RANGE_CHECK(WIDTH, 1, 32)
    `PIPE_RANGE_CHECK(DEPTH, 1, 16)

    mode_e            w_mode;
    logic [WIDTH-1:0] w_stage_q [DEPTH];
    logic [CW-1:0]    r_fill;
    logic             r_qv;

    always_comb begin
        w_mode = MODE_HOLD;
        if (SET) begin
            w_mode = MODE_SET;
        end else if (SE) begin
            w_mode = MODE_SCAN;
        end else if (E) begin
            w_mode = MODE_SHIFT;
        end
    end

    // Stage 0 is the chain LSB end: it takes D in shift mode and SI in scan mode.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            dffn_pipe_stage #(
                .WIDTH    (WIDTH),
                .RESET_VAL(RESET_VAL),
                .SET_VAL  (SET_VAL)
            ) u_stage (
                .i_clkn(CLKN),
                .i_rst (R),
                .i_mode(w_mode),
                .i_d   (D),
                .i_si  (SI),
                .o_q   (w_stage_q[0])
            );
        end else begin : g_body
            dffn_pipe_stage #(
                .WIDTH    (WIDTH),
                .RESET_VAL(RESET_VAL),
                .SET_VAL  (SET_VAL)
            ) u_stage (
                .i_clkn(CLKN),
                .i_rst (R),
                .i_mode(w_mode),
                .i_d   (w_stage_q[k-1]),
                .i_si  (w_stage_q[k-1][WIDTH-1]),
                .o_q   (w_stage_q[k])
            );
        end
    end

    // Scanned or set contents are not pipeline data, so both restart the fill count.
    always_ff @(negedge CLKN or posedge R) begin
        if (R) begin
            r_fill <= '0;
            r_qv   <= 1'b0;
        end else begin
            case (w_mode)
                MODE_SET, MODE_SCAN: begin
                    r_fill <= '0;
                    r_qv   <= 1'b0;
                end
                MODE_SHIFT: begin
                    if (r_fill != FULL) begin
                        r_fill <= r_fill + 1'b1;
                        r_qv   <= (r_fill == LAST);
                    end
                end
                default: begin
                    r_fill <= r_fill;
                    r_qv   <= r_qv;
                end
            endcase
        end
    end

    assign Q  = w_stage_q[DEPTH-1];
    assign QV = r_qv;
    assign SO = w_stage_q[DEPTH-1][WIDTH-1];

endmodule

// File: tb/tb_dffn_pipe_rs.sv
// Bench for dffn_pipe_rs: vector table, corner sequences (async reset, scan,
// single-stage build) and randomized traffic against an array-based model.
module tb_dffn_pipe_rs;

    localparam int W   = 4;
    localparam int N   = 3;
    localparam int CHW = W * N;

    logic         clkn;
    logic         r, e, set, se, si;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         qv, so;

    logic         c_r, c_e, c_set, c_se, c_si;
    logic [0:0]   c_d;
    logic [0:0]   c_q;
    logic         c_qv, c_so;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic         r, e, set, se, si;
        logic [W-1:0] d;
        logic [W-1:0] q;
        logic         qv, so;
    } vec_t;

    vec_t vecs [19];

    logic [W-1:0]   m_st [N];
    int             m_fill;
    logic [W+1:0]   exp_q [$];

    dffn_pipe_rs #(.WIDTH(W), .DEPTH(N)) u_dut (
        .CLKN(clkn), .R(r), .E(e), .SET(set), .SE(se), .SI(si),
        .D(d), .Q(q), .QV(qv), .SO(so)
    );

    dffn_pipe_rs #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b1), .SET_VAL(1'b1)) u_c (
        .CLKN(clkn), .R(c_r), .E(c_e), .SET(c_set), .SE(c_se), .SI(c_si),
        .D(c_d), .Q(c_q), .QV(c_qv), .SO(c_so)
    );

    initial clkn = 1'b1;
    always #5 clkn = ~clkn;

    task automatic step();
        @(negedge clkn);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic vr, input logic ve, input logic vset, input logic vse,
                                input logic vsi, input logic [W-1:0] vd,
                                input logic [W-1:0] vq, input logic vqv, input logic vso);
        vec_t v;
        v.r = vr; v.e = ve; v.set = vset; v.se = vse; v.si = vsi; v.d = vd;
        v.q = vq; v.qv = vqv; v.so = vso;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_st[i] = '0;
        m_fill = 0;
    endtask

    task automatic model_edge(input logic mr, input logic me, input logic mset, input logic mse,
                              input logic msi, input logic [W-1:0] md);
        logic [CHW-1:0] chain;
        if (mr) begin
            model_reset();
        end else if (mset) begin
            for (int i = 0; i < N; i++) m_st[i] = '1;
            m_fill = 0;
        end else if (mse) begin
            chain = '0;
            for (int i = N - 1; i >= 0; i--) chain = (chain << W) | CHW'(m_st[i]);
            chain = (chain << 1) | CHW'(msi);
            for (int i = 0; i < N; i++) m_st[i] = W'(chain >> (W * i));
            m_fill = 0;
        end else if (me) begin
            for (int i = N - 1; i > 0; i--) m_st[i] = m_st[i-1];
            m_st[0] = md;
            m_fill = (m_fill + 1 > N) ? N : m_fill + 1;
        end
    endtask

    initial begin
        r = 1'b1; e = 1'b0; set = 1'b0; se = 1'b0; si = 1'b0; d = '0;
        c_r = 1'b1; c_e = 1'b0; c_set = 1'b0; c_se = 1'b0; c_si = 1'b0; c_d = '0;

        vecs[0]  = mk(1, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 4'h1, 4'h0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 4'h2, 4'h0, 0, 0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 4'h3, 4'h1, 1, 0);
        vecs[4]  = mk(0, 1, 0, 0, 0, 4'h4, 4'h2, 1, 0);
        for (int k = 0; k < 5; k++) vecs[5+k] = mk(0, 0, 0, 0, 0, W'(5 + k), 4'h2, 1, 0);
        vecs[10] = mk(0, 1, 0, 0, 0, 4'hA, 4'h3, 1, 0);
        vecs[11] = mk(0, 1, 0, 0, 0, 4'hB, 4'h4, 1, 0);
        vecs[12] = mk(0, 1, 0, 0, 0, 4'hC, 4'hA, 1, 1);
        vecs[13] = mk(0, 1, 1, 1, 0, 4'h0, 4'hF, 0, 1);
        vecs[14] = mk(0, 1, 0, 0, 0, 4'h1, 4'hF, 0, 1);
        vecs[15] = mk(0, 1, 0, 0, 0, 4'h2, 4'hF, 0, 1);
        vecs[16] = mk(0, 1, 0, 0, 0, 4'h3, 4'h1, 1, 0);
        vecs[17] = mk(0, 1, 0, 1, 1, 4'h0, 4'h2, 0, 0);
        vecs[18] = mk(0, 1, 0, 0, 0, 4'h5, 4'h4, 0, 0);

        for (int i = 0; i < 19; i++) begin
            r = vecs[i].r; e = vecs[i].e; set = vecs[i].set;
            se = vecs[i].se; si = vecs[i].si; d = vecs[i].d;
            step();
            check($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].q));
            check($sformatf("vec%0d_qv", i), 32'(qv), 32'(vecs[i].qv));
            check($sformatf("vec%0d_so", i), 32'(so), 32'(vecs[i].so));
        end

        // Async reset while CLKN is high: outputs must clear before any falling edge.
        r = 1'b0; e = 1'b0; se = 1'b0; set = 1'b1;
        step();
        set = 1'b0;
        check("pre_async_q", 32'(q), 32'hF);
        @(posedge clkn);
        #2;
        r = 1'b1;
        #1;
        check("async_q", 32'(q), 32'h0);
        check("async_qv", 32'(qv), 32'h0);
        check("async_so", 32'(so), 32'h0);
        r = 1'b0;
        step();
        check("async_hold_q", 32'(q), 32'h0);

        // Scan a single one through all twelve chain bits.
        se = 1'b1;
        for (int k = 1; k <= CHW; k++) begin
            si = (k == 1);
            step();
            check($sformatf("scan%0d_so", k), 32'(so), 32'(k == CHW));
        end
        check("scan_qv", 32'(qv), 32'h0);
        se = 1'b0; si = 1'b0;
        step();
        check("scan_after_q", 32'(q), 32'h8);
        check("scan_after_qv", 32'(qv), 32'h0);

        // Single-stage, single-bit build with RESET_VAL=1.
        check("c_reset_q", 32'(c_q), 32'h1);
        check("c_reset_qv", 32'(c_qv), 32'h0);
        c_r = 1'b0; c_e = 1'b1; c_d = 1'b0;
        step();
        check("c_edge_q", 32'(c_q), 32'h0);
        check("c_edge_qv", 32'(c_qv), 32'h1);
        check("c_edge_so", 32'(c_so), 32'h0);
        c_e = 1'b0;
        @(posedge clkn);
        #2;
        c_r = 1'b1;
        #1;
        check("c_async_q", 32'(c_q), 32'h1);
        check("c_async_qv", 32'(c_qv), 32'h0);
        c_r = 1'b0;

        // Randomized traffic against the reference model.
        r = 1'b1; e = 1'b0; set = 1'b0; se = 1'b0; si = 1'b0; d = '0;
        step();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 19) == 0);
            set = ($urandom_range(0, 9) == 0);
            se  = ($urandom_range(0, 4) == 0);
            e   = ($urandom_range(0, 2) != 0);
            si  = 1'($urandom_range(0, 1));
            d   = W'($urandom_range(0, 15));
            model_edge(r, e, set, se, si, d);
            exp_q.push_back({m_st[N-1], (m_fill == N), m_st[N-1][W-1]});
            step();
            check($sformatf("rand%0d", n), 32'({q, qv, so}), 32'(exp_q.pop_front()));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
